apu_wr_arbiter: RTL and testbench

APU_WR_ARBITER -- requirements
Module: apu_wr_arbiter

---
 rtl/apu_wr_arbiter_pkg.sv | 6 +
 rtl/apu_wr_arbiter_wr_fifo.sv | 40 ++++
 rtl/apu_wr_arbiter.sv | 71 +++++++
 tb/tb_apu_wr_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/apu_wr_arbiter_pkg.sv
// apu_wr_arbiter_pkg: register-file constants shared by apu, reg_file and the write arbiter
package apu_wr_arbiter_pkg;
  localparam int rf_data_width = 32;
  localparam int rf_sel_width = 5;
  localparam int apu_fifo_depth = 4;
endpackage

// File: rtl/apu_wr_arbiter_wr_fifo.sv
// wr_fifo: power-of-two deep result buffer; occupancy count distinguishes full from empty
module wr_fifo
  import apu_wr_arbiter_pkg::*;
#(
  parameter int width = rf_data_width + rf_sel_width,
  parameter int depth = apu_fifo_depth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wptr, rptr;
  logic [aw:0] count;
  logic push_ok, pop_ok;
  assign full = count == (aw+1)'(depth);
  assign empty = count == '0;
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;
  assign rdata = mem[rptr];
  always_ff @(posedge clk)
    if (push_ok) mem[wptr] <= wdata;
  // pointers wrap naturally because depth is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      count <= count + (aw+1)'(push_ok) - (aw+1)'(pop_ok);
    end
endmodule

// File: rtl/apu_wr_arbiter.sv
// apu_wr_arbiter: merges processor and buffered APU writebacks onto one register-file port
module apu_wr_arbiter
  import apu_wr_arbiter_pkg::*;
#(
  parameter int data_width = rf_data_width,
  parameter int reg_sel_width = rf_sel_width,
  parameter int fifo_depth = apu_fifo_depth
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        apu_wr_req,
  input  logic [reg_sel_width-1:0]    apu_wr_sel,
  input  logic [data_width-1:0]       apu_wr_data,
  output logic                        apu_ack,
  input  logic                        proc_wr_req,
  input  logic [reg_sel_width-1:0]    proc_wr_sel,
  input  logic [data_width-1:0]       proc_wr_data,
  input  logic                        apu_issue,
  input  logic [reg_sel_width-1:0]    apu_issue_sel,
  output logic [2**reg_sel_width-1:0] pending,
  output logic                        rf_wr_req,
  output logic [reg_sel_width-1:0]    rf_wr_sel,
  output logic [data_width-1:0]       rf_wr_data,
  output logic                        err
);
  localparam int nr = 2**reg_sel_width;
  localparam int ew = data_width + reg_sel_width;
  logic full, empty, pop, viol;
  logic [ew-1:0] head;
  logic [reg_sel_width-1:0] head_sel;
  logic [data_width-1:0] head_data;
  logic [nr-1:0] set_vec, clr_vec, pending_nxt;
  assign {head_sel, head_data} = head;
  assign apu_ack = apu_wr_req & ~full & ~rst;
  assign pop = ~proc_wr_req & ~empty;
  wr_fifo #(.width(ew), .depth(fifo_depth)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (apu_ack),
    .pop   (pop),
    .wdata ({apu_wr_sel, apu_wr_data}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  // a result acked in the same cycle its op issues counts as expected
  always_comb begin
    set_vec = (apu_issue && apu_issue_sel != '0) ? nr'(1) << apu_issue_sel : '0;
    clr_vec = pop ? nr'(1) << head_sel : '0;
    pending_nxt = ((pending & ~clr_vec) | set_vec) & ~nr'(1);
    viol = (proc_wr_req && pending[proc_wr_sel])
        || (|(set_vec & pending & ~clr_vec))
        || (apu_ack && apu_wr_sel != '0 && !(pending[apu_wr_sel] || set_vec[apu_wr_sel]));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      err <= 1'b0;
      rf_wr_req <= 1'b0;
      rf_wr_sel <= '0;
      rf_wr_data <= '0;
    end else begin
      pending <= pending_nxt;
      err <= err | viol;
      rf_wr_req <= proc_wr_req ? proc_wr_sel != '0 : pop && head_sel != '0;
      if (proc_wr_req || pop) begin
        rf_wr_sel <= proc_wr_req ? proc_wr_sel : head_sel;
        rf_wr_data <= proc_wr_req ? proc_wr_data : head_data;
      end
    end
endmodule

// File: tb/tb_apu_wr_arbiter.sv
// tb_apu_wr_arbiter: directed vectors with hand-computed expectations for the write arbiter
module tb_apu_wr_arbiter;
  logic clk, rst;
  logic apu_wr_req, apu_ack, proc_wr_req, apu_issue, rf_wr_req, err;
  logic [4:0] apu_wr_sel, proc_wr_sel, apu_issue_sel, rf_wr_sel;
  logic [31:0] apu_wr_data, proc_wr_data, rf_wr_data, pending;
  int checks = 0;
  int errors = 0;

  apu_wr_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .apu_wr_req    (apu_wr_req),
    .apu_wr_sel    (apu_wr_sel),
    .apu_wr_data   (apu_wr_data),
    .apu_ack       (apu_ack),
    .proc_wr_req   (proc_wr_req),
    .proc_wr_sel   (proc_wr_sel),
    .proc_wr_data  (proc_wr_data),
    .apu_issue     (apu_issue),
    .apu_issue_sel (apu_issue_sel),
    .pending       (pending),
    .rf_wr_req     (rf_wr_req),
    .rf_wr_sel     (rf_wr_sel),
    .rf_wr_data    (rf_wr_data),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    apu_wr_req = 1'b1; apu_wr_sel = 5'd3; apu_wr_data = '0;
    proc_wr_req = 1'b0; proc_wr_sel = '0; proc_wr_data = '0;
    apu_issue = 1'b0; apu_issue_sel = '0;
    @(posedge clk);
    #1;
    check("ack_in_rst", apu_ack, 0);
    check("rst_rf_req", rf_wr_req, 0);
    check("rst_pending", pending, 0);
    check("rst_err", err, 0);
    apu_wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single APU result, sel 11
    apu_issue = 1'b1; apu_issue_sel = 5'd11;
    tick();
    apu_issue = 1'b0;
    check("pend11_set", pending[11], 1);
    apu_wr_req = 1'b1; apu_wr_sel = 5'd11; apu_wr_data = 32'd23;
    #1;
    check("ack11", apu_ack, 1);
    tick();
    apu_wr_req = 1'b0;
    check("rf_n1_idle", rf_wr_req, 0);
    check("pend11_hold", pending[11], 1);
    tick();
    check("rf11_req", rf_wr_req, 1);
    check("rf11_sel", rf_wr_sel, 11);
    check("rf11_data", rf_wr_data, 23);
    check("pend11_clr", pending[11], 0);
    tick();
    check("rf_idle", rf_wr_req, 0);

    // proc and APU in the same cycle
    apu_issue = 1'b1; apu_issue_sel = 5'd7;
    tick();
    apu_issue = 1'b0;
    proc_wr_req = 1'b1; proc_wr_sel = 5'd3; proc_wr_data = 32'd5;
    apu_wr_req = 1'b1; apu_wr_sel = 5'd7; apu_wr_data = 32'd321;
    #1;
    check("ack7", apu_ack, 1);
    tick();
    proc_wr_req = 1'b0; apu_wr_req = 1'b0;
    check("rf3_sel", rf_wr_sel, 3);
    check("rf3_data", rf_wr_data, 5);
    tick();
    check("rf7_req", rf_wr_req, 1);
    check("rf7_sel", rf_wr_sel, 7);
    check("rf7_data", rf_wr_data, 321);
    check("pend7_clr", pending[7], 0);
    tick();

    // sel 0 result
    apu_wr_req = 1'b1; apu_wr_sel = 5'd0; apu_wr_data = 32'd99;
    #1;
    check("ack0", apu_ack, 1);
    tick();
    apu_wr_req = 1'b0;
    tick();
    check("rf0_noreq", rf_wr_req, 0);
    check("err_sel0", err, 0);

    // five results with processor holding the port
    for (int i = 1; i <= 5; i++) begin
      apu_issue = 1'b1; apu_issue_sel = 5'(i);
      tick();
    end
    apu_issue = 1'b0;
    check("pend_1to5", pending, 32'h3e);
    proc_wr_req = 1'b1; proc_wr_sel = 5'd20; proc_wr_data = '0;
    for (int k = 1; k <= 4; k++) begin
      apu_wr_req = 1'b1; apu_wr_sel = 5'(k); apu_wr_data = 32'(100 + k);
      #1;
      check("ack_fill", apu_ack, 1);
      tick();
    end
    check("rf_proc20", rf_wr_sel, 20);
    apu_wr_sel = 5'd5; apu_wr_data = 32'd105;
    #1;
    check("ack_full", apu_ack, 0);
    tick();
    check("ack_full2", apu_ack, 0);
    check("starve_sel", rf_wr_sel, 20);
    proc_wr_req = 1'b0;
    #1;
    check("ack_full3", apu_ack, 0);
    tick();
    check("drain1_sel", rf_wr_sel, 1);
    check("drain1_data", rf_wr_data, 101);
    check("ack5", apu_ack, 1);
    tick();
    apu_wr_req = 1'b0;
    check("drain2_sel", rf_wr_sel, 2);
    check("drain2_data", rf_wr_data, 102);
    for (int k = 3; k <= 5; k++) begin
      tick();
      check("drain_req", rf_wr_req, 1);
      check("drain_sel", rf_wr_sel, 5'(k));
      check("drain_data", rf_wr_data, 32'(100 + k));
    end
    tick();
    check("drain_idle", rf_wr_req, 0);
    check("drain_pend", pending, 0);
    check("drain_err", err, 0);

    // proc write to a pending register
    apu_issue = 1'b1; apu_issue_sel = 5'd9;
    tick();
    apu_issue = 1'b0;
    proc_wr_req = 1'b1; proc_wr_sel = 5'd9; proc_wr_data = 32'd77;
    tick();
    proc_wr_req = 1'b0;
    check("err9", err, 1);
    check("rf9_req", rf_wr_req, 1);
    check("rf9_sel", rf_wr_sel, 9);
    tick(); tick(); tick();
    check("err9_sticky", err, 1);

    // reset with three buffered entries
    proc_wr_req = 1'b1; proc_wr_sel = 5'd21; proc_wr_data = 32'd1;
    for (int i = 0; i < 3; i++) begin
      apu_issue = 1'b1; apu_issue_sel = 5'(12 + i);
      tick();
    end
    apu_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apu_wr_req = 1'b1; apu_wr_sel = 5'(12 + i); apu_wr_data = 32'(200 + i);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", rf_wr_req, 0);
    check("arst_sel", rf_wr_sel, 0);
    check("arst_data", rf_wr_data, 0);
    check("arst_pend", pending, 0);
    check("arst_err", err, 0);
    check("arst_ack", apu_ack, 0);
    proc_wr_req = 1'b0; apu_wr_req = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst1", rf_wr_req, 0);
    tick();
    check("post_rst2", rf_wr_req, 0);

    // re-issue to an already-pending register
    apu_issue = 1'b1; apu_issue_sel = 5'd2;
    tick();
    check("reissue_ok", err, 0);
    tick();
    apu_issue = 1'b0;
    check("reissue_err", err, 1);
    do_reset();
    check("reissue_rst", err, 0);

    // ack for a register with no outstanding op
    apu_wr_req = 1'b1; apu_wr_sel = 5'd15; apu_wr_data = 32'd7;
    #1;
    check("ack15", apu_ack, 1);
    tick();
    apu_wr_req = 1'b0;
    check("err15", err, 1);
    tick();
    check("rf15_req", rf_wr_req, 1);
    check("rf15_sel", rf_wr_sel, 15);
    check("rf15_data", rf_wr_data, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
